// File: rtl/scan_controller.sv
// scan_controller: command-side controller for a primary/alternate scanner pair.
//   - Relays each scanner's start/standby status edges to the other scanner as 1-cycle commands.
//   - Arbitrates the single flush downlink (req/gnt with the uplink radio), issues the flush
//     command, tracks the transfer and accumulates the number of units flushed.
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-high reset
//   rdy_flushN, start_scan_outN,
//   goto_stby_outN, mem_usedN,
//   stateN                          status from scanner N (N = 1, 2)
//   start_scan_inN, goto_stby_inN,
//   flushN                          commands to scanner N
//   uplink_req / uplink_gnt         downlink request / grant
//   xfer_active                     flush in progress
//   xfer_sel                        selected scanner (0 = scanner 1, 1 = scanner 2)
//   xfer_total                      cumulative units flushed (wraps)
//   xfer_err                        sticky error (ack timeout or grant lost mid-flush)
module scan_controller #(
  parameter int unsigned TOTAL_W     = 16,
  parameter int unsigned COOLDOWN    = 4,
  parameter int unsigned ACK_TIMEOUT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rdy_flush1,
  input  logic               start_scan_out1,
  input  logic               goto_stby_out1,
  input  logic [7:0]         mem_used1,
  input  logic [2:0]         state1,
  input  logic               rdy_flush2,
  input  logic               start_scan_out2,
  input  logic               goto_stby_out2,
  input  logic [7:0]         mem_used2,
  input  logic [2:0]         state2,
  output logic               start_scan_in1,
  output logic               goto_stby_in1,
  output logic               flush1,
  output logic               start_scan_in2,
  output logic               goto_stby_in2,
  output logic               flush2,
  output logic               uplink_req,
  input  logic               uplink_gnt,
  output logic               xfer_active,
  output logic               xfer_sel,
  output logic [TOTAL_W-1:0] xfer_total,
  output logic               xfer_err
);

  localparam logic [2:0] ScanLowPwr   = 3'b000;
  localparam logic [2:0] ScanFlushing = 3'b100;
  localparam int unsigned AckW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned CoolW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFlushCmd,
    StWaitAck,
    StFlush,
    StCool
  } state_e;

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic [7:0]         prev_mem_q, prev_mem_d;
  logic [AckW-1:0]    ack_cnt_q, ack_cnt_d;
  logic [CoolW-1:0]   cool_cnt_q, cool_cnt_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               err_q, err_d;

  // Cross relay: previous samples and registered pulses
  logic sso1_prev_q, gso1_prev_q, sso2_prev_q, gso2_prev_q;
  logic ssi1_q, gsi1_q, ssi2_q, gsi2_q;

  logic [7:0] sel_mem;
  logic [2:0] sel_state;

  assign sel_mem   = sel_q ? mem_used2 : mem_used1;
  assign sel_state = sel_q ? state2 : state1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sso1_prev_q <= 1'b0;
      gso1_prev_q <= 1'b0;
      sso2_prev_q <= 1'b0;
      gso2_prev_q <= 1'b0;
      ssi1_q      <= 1'b0;
      gsi1_q      <= 1'b0;
      ssi2_q      <= 1'b0;
      gsi2_q      <= 1'b0;
    end else begin
      sso1_prev_q <= start_scan_out1;
      gso1_prev_q <= goto_stby_out1;
      sso2_prev_q <= start_scan_out2;
      gso2_prev_q <= goto_stby_out2;
      // Scanner 1 status edges command scanner 2 and vice versa
      ssi2_q      <= start_scan_out1 & ~sso1_prev_q;
      gsi2_q      <= goto_stby_out1 & ~gso1_prev_q;
      ssi1_q      <= start_scan_out2 & ~sso2_prev_q;
      gsi1_q      <= goto_stby_out2 & ~gso2_prev_q;
    end
  end

  assign start_scan_in1 = ssi1_q;
  assign goto_stby_in1  = gsi1_q;
  assign start_scan_in2 = ssi2_q;
  assign goto_stby_in2  = gsi2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= 1'b0;
      prev_mem_q <= '0;
      ack_cnt_q  <= '0;
      cool_cnt_q <= '0;
      total_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      prev_mem_q <= prev_mem_d;
      ack_cnt_q  <= ack_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      total_q    <= total_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    prev_mem_d  = prev_mem_q;
    ack_cnt_d   = ack_cnt_q;
    cool_cnt_d  = cool_cnt_q;
    total_d     = total_q;
    err_d       = err_q;
    uplink_req  = 1'b0;
    xfer_active = 1'b0;
    flush1      = 1'b0;
    flush2      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rdy_flush1 || rdy_flush2) begin
          // Both ready: fuller memory wins, ties go to scanner 1
          if (rdy_flush1 && rdy_flush2) sel_d = (mem_used2 > mem_used1);
          else                          sel_d = rdy_flush2;
          state_d = StReq;
        end
      end
      StReq: begin
        uplink_req = 1'b1;
        if (uplink_gnt) state_d = StFlushCmd;
      end
      StFlushCmd: begin
        uplink_req = 1'b1;
        flush1     = ~sel_q;
        flush2     = sel_q;
        prev_mem_d = sel_mem;
        ack_cnt_d  = '0;
        state_d    = StWaitAck;
      end
      StWaitAck: begin
        uplink_req = 1'b1;
        if (sel_state == ScanFlushing) begin
          state_d = StFlush;
        end else if (ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          cool_cnt_d = '0;
          state_d    = StCool;
        end else begin
          ack_cnt_d = ack_cnt_q + AckW'(1);
        end
      end
      StFlush: begin
        uplink_req  = 1'b1;
        xfer_active = 1'b1;
        // The scanner cannot be aborted, so a lost grant is only flagged
        if (!uplink_gnt) err_d = 1'b1;
        // Only decreases count as flushed; refills are ignored
        if (sel_mem < prev_mem_q) total_d = total_q + TOTAL_W'(prev_mem_q - sel_mem);
        prev_mem_d = sel_mem;
        if (sel_state == ScanLowPwr && sel_mem == 8'd0) begin
          cool_cnt_d = '0;
          state_d    = StCool;
        end
      end
      StCool: begin
        if (cool_cnt_q == CoolW'(COOLDOWN - 1)) state_d = StIdle;
        else                                    cool_cnt_d = cool_cnt_q + CoolW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  assign xfer_sel   = sel_q;
  assign xfer_total = total_q;
  assign xfer_err   = err_q;

endmodule
